aes_dfa_sequencer: RTL and testbench
====================================

# aes_dfa_sequencer

Fault-campaign controller wrapped around the pipelined AES-128 fault-injection core. It accepts one plaintext/key command and runs one fault-free "golden" encryption. It then runs a sweep of single-bit round-9 faulted encryptions, driving the core's `state`, `key`, `fault_en` and `fault_bit` inputs and sampling its `out` port. For each faulty ciphertext it emits the golden/faulty pair, their XOR difference and a single-byte-difference check on a valid/ready result stream.

## Interface
Parameters:
- `LAT`, 11 — cycles from the launch cycle L to the cycle in which the core `out` holds that run's ciphertext.
- `FAULT_AT`, 10 — offset from L of the single cycle in which `aes_fault_en` is high; must be less than `LAT`.

Ports:
- `clk`  in  1  — sole clock; all logic on the rising edge.
- `rst`  in  1  — synchronous reset, active-high.
- `cmd_valid`  in  1  — command offered.
- `cmd_ready`  out  1  — high only in IDLE.
- `cmd_pt`  in  128  — plaintext.
- `cmd_key`  in  128  — cipher key.
- `cmd_bit_start`  in  7  — first fault bit index.
- `cmd_count`  in  7  — number of faulted runs; 0 means 128.
- `aes_state`  out  128  — to core `state`.
- `aes_key`  out  128  — to core `key`.
- `aes_fault_en`  out  1  — to core `fault_en`; registered.
- `aes_fault_bit`  out  7  — to core `fault_bit`; registered.
- `aes_out`  in  128  — from core `out`.
- `res_valid`  out  1  — result valid.
- `res_ready`  in  1  — result accepted.
- `res_golden`  out  128  — fault-free ciphertext.
- `res_faulty`  out  128  — faulty ciphertext.
- `res_diff`  out  128  — golden XOR faulty.
- `res_fault_bit`  out  7  — bit index faulted for this result.
- `res_byte_idx`  out  4  — lowest-indexed nonzero byte of the diff; byte 0 is bits [127:120].
- `res_single_byte`  out  1  — diff is nonzero in exactly one byte.
- `res_last`  out  1  — final result of the command.
- `busy`  out  1  — not in IDLE.

## Operation
States are IDLE, GOLD_RUN, FAULT_RUN and RESP.

- **IDLE**
  - On `cmd_valid && cmd_ready`: latch `cmd_pt` into `aes_state` and `cmd_key` into `aes_key`.
  - Latch the start bit and count; load the internal remaining-runs counter with 128 if `cmd_count == 0`.
  - Go to GOLD_RUN.
- **GOLD_RUN**
  - A cycle counter `cyc` starts at 0 on entry; `cyc == 0` is launch cycle L.
  - `aes_fault_en` stays 0 for the whole run.
  - In the cycle with `cyc == LAT`, capture `aes_out` into the golden register, then go to FAULT_RUN with `cur_bit = bit_start`.
- **FAULT_RUN**
  - Same timing as GOLD_RUN.
  - `aes_fault_en` = 1 and `aes_fault_bit` = `cur_bit` exactly in the cycle with `cyc == FAULT_AT`; `aes_fault_en` is 0 in every other cycle.
  - In the cycle with `cyc == LAT`, capture `aes_out` into the faulty register and go to RESP.
- **RESP**
  - `res_valid` = 1; all `res_*` outputs are held stable until the handshake.
  - On `res_valid && res_ready`: decrement the remaining-runs counter.
  - If that result had `res_last` = 1, go to IDLE; otherwise set `cur_bit = cur_bit + 1` (7-bit wrap, 127 → 0) and go to FAULT_RUN.

Result field rules:
- `res_last` = 1 when the remaining-runs counter is 1.
- `res_diff` = golden ^ faulty.
- `res_single_byte` = 1 iff exactly one of the 16 bytes of `res_diff` is nonzero.
- `res_byte_idx` = index of the lowest-indexed nonzero byte; 0 if `res_diff` is all zero.
- `aes_state` and `aes_key` are held constant from command accept until the command completes, so the core pipeline never sees a mixed input.
- `cmd_valid` is ignored while `busy` = 1.

Reset:
- `rst` in any state returns to IDLE on the next edge.
- Every output resets to 0 except `cmd_ready`, which is 1 after reset.
- A partial campaign is discarded; no result is emitted for it.
- A capture from a run aborted by reset never appears on the result stream.

## Timing
- Core output arrives `LAT` = 11 cycles after L; the core's round-9 register output is faulted at L+`FAULT_AT` = L+10.
- `res_valid` rises in cycle L+`LAT`+1 of a faulted run.
- With `res_ready` held high, each faulted run takes 12 cycles plus 1 for the handshake, and a new launch follows in the cycle after the handshake.
- The golden run adds 12 cycles before the first faulted run.
- `cmd_ready` falls in the cycle after the command handshake.
- After the last handshake, `cmd_ready` is 1 in the next cycle.
- Only one encryption is ever in flight in the core.

## Test plan
- **Single fault, bit 0.** FIPS-197 key 000102…0f, plaintext 00112233…ff, `cmd_count` = 1, `cmd_bit_start` = 0.
  - `res_golden` = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - `res_fault_bit` = 0, `res_single_byte` = 1, `res_byte_idx` = 3, `res_last` = 1.
- **Single fault, bit 127.** Same vector, `cmd_bit_start` = 127.
  - `res_byte_idx` = 0, `res_single_byte` = 1.
  - `res_diff` is zero outside bits [127:120].
- **Wrap-around.** `cmd_bit_start` = 126, `cmd_count` = 4.
  - Results arrive for bits 126, 127, 0, 1 in that order; `res_last` = 1 only on bit 1.
  - `res_golden` is identical in all four results.
- **Full sweep and fault_en timing.** `cmd_count` = 0.
  - Exactly 128 results; the last has `res_fault_bit` = `cmd_bit_start` − 1.
  - `aes_fault_en` is high exactly one cycle per faulted run, at L+10, and never during the golden run.
  - `cmd_ready` is 0 throughout.
- **Backpressure.** Hold `res_ready` low for 20 cycles in RESP.
  - All `res_*` outputs are stable, no new launch occurs, and `aes_fault_en` stays 0.
  - After `res_ready` = 1, the next run launches one cycle after the handshake.
- **Reset mid-run.** Assert `rst` at L+10 of a faulted run.
  - Next cycle: `aes_fault_en` = 0, `res_valid` = 0, `busy` = 0, `cmd_ready` = 1.
  - A fresh command then completes with correct values.

Source files
------------

// File: rtl/aes_dfa_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : aes_dfa_sequencer
//  Description : Runs one golden AES-128 encryption, then a sweep of single-bit
//                round-9 faulted encryptions, streaming golden/faulty pairs.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_dfa_sequencer #(
    parameter int LAT      = 11,
    parameter int FAULT_AT = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [127:0] cmd_pt,
    input  logic [127:0] cmd_key,
    input  logic [6:0]   cmd_bit_start,
    input  logic [6:0]   cmd_count,
    output logic [127:0] aes_state,
    output logic [127:0] aes_key,
    output logic         aes_fault_en,
    output logic [6:0]   aes_fault_bit,
    input  logic [127:0] aes_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_golden,
    output logic [127:0] res_faulty,
    output logic [127:0] res_diff,
    output logic [6:0]   res_fault_bit,
    output logic [3:0]   res_byte_idx,
    output logic         res_single_byte,
    output logic         res_last,
    output logic         busy
);

    localparam int            CW         = $clog2(LAT + 1);
    localparam logic [CW-1:0] C_LAT      = CW'(LAT);
    localparam logic [CW-1:0] C_FAULT_AT = CW'(FAULT_AT);
    localparam logic [CW-1:0] C_ONE      = CW'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GOLD_RUN  = 2'd1,
        FAULT_RUN = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cyc_q, cyc_d;
    logic [6:0]     cur_bit_q, cur_bit_d;
    logic [7:0]     remaining_q, remaining_d;
    logic           fault_en_d;
    logic           w_accept, w_cap_gold, w_cap_fault, w_handshake;

    logic           cmd_ready_q, busy_q, fault_en_q, res_valid_q;
    logic [6:0]     fault_bit_q, res_fault_bit_q;
    logic [127:0]   aes_state_q, aes_key_q, golden_q, res_faulty_q, res_diff_q;
    logic [3:0]     res_byte_idx_q;
    logic           res_single_q, res_last_q;

    logic [127:0]   w_diff;
    logic [4:0]     w_nz_cnt;
    logic [3:0]     w_byte_idx;
    logic           w_found;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        cur_bit_d   = cur_bit_q;
        remaining_d = remaining_q;
        w_accept    = 1'b0;
        w_cap_gold  = 1'b0;
        w_cap_fault = 1'b0;
        w_handshake = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    w_accept    = 1'b1;
                    state_d     = GOLD_RUN;
                    cyc_d       = '0;
                    cur_bit_d   = cmd_bit_start;
                    remaining_d = (cmd_count == 7'd0) ? 8'd128 : {1'b0, cmd_count};
                end
            end
            GOLD_RUN: begin
                if (cyc_q == C_LAT) begin
                    w_cap_gold = 1'b1;
                    state_d    = FAULT_RUN;
                    cyc_d      = '0;
                end else begin
                    cyc_d = cyc_q + C_ONE;
                end
            end
            FAULT_RUN: begin
                if (cyc_q == C_LAT) begin
                    w_cap_fault = 1'b1;
                    state_d     = RESP;
                end else begin
                    cyc_d = cyc_q + C_ONE;
                end
            end
            RESP: begin
                if (res_ready) begin
                    w_handshake = 1'b1;
                    remaining_d = remaining_q - 8'd1;
                    if (res_last_q) begin
                        state_d = IDLE;
                    end else begin
                        cur_bit_d = cur_bit_q + 7'd1;
                        state_d   = FAULT_RUN;
                        cyc_d     = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Fault strobe is registered, so it is decided from the next-cycle position.
        fault_en_d = (state_d == FAULT_RUN) && (cyc_d == C_FAULT_AT);
    end

    always_comb begin
        w_diff     = golden_q ^ aes_out;
        w_nz_cnt   = '0;
        w_byte_idx = '0;
        w_found    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (w_diff[127-8*i -: 8] != 8'h00) begin
                w_nz_cnt = w_nz_cnt + 5'd1;
                if (!w_found) begin
                    w_byte_idx = 4'(i);
                    w_found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cyc_q           <= '0;
            cur_bit_q       <= '0;
            remaining_q     <= '0;
            cmd_ready_q     <= 1'b1;
            busy_q          <= 1'b0;
            fault_en_q      <= 1'b0;
            fault_bit_q     <= '0;
            aes_state_q     <= '0;
            aes_key_q       <= '0;
            golden_q        <= '0;
            res_valid_q     <= 1'b0;
            res_faulty_q    <= '0;
            res_diff_q      <= '0;
            res_fault_bit_q <= '0;
            res_byte_idx_q  <= '0;
            res_single_q    <= 1'b0;
            res_last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            cur_bit_q   <= cur_bit_d;
            remaining_q <= remaining_d;
            cmd_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            fault_en_q  <= fault_en_d;
            if (fault_en_d) begin
                fault_bit_q <= cur_bit_d;
            end
            if (w_accept) begin
                aes_state_q <= cmd_pt;
                aes_key_q   <= cmd_key;
            end
            if (w_cap_gold) begin
                golden_q <= aes_out;
            end
            if (w_cap_fault) begin
                res_valid_q     <= 1'b1;
                res_faulty_q    <= aes_out;
                res_diff_q      <= w_diff;
                res_fault_bit_q <= cur_bit_q;
                res_byte_idx_q  <= w_byte_idx;
                res_single_q    <= (w_nz_cnt == 5'd1);
                res_last_q      <= (remaining_q == 8'd1);
            end else if (w_handshake) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign busy            = busy_q;
    assign aes_state       = aes_state_q;
    assign aes_key         = aes_key_q;
    assign aes_fault_en    = fault_en_q;
    assign aes_fault_bit   = fault_bit_q;
    assign res_valid       = res_valid_q;
    assign res_golden      = golden_q;
    assign res_faulty      = res_faulty_q;
    assign res_diff        = res_diff_q;
    assign res_fault_bit   = res_fault_bit_q;
    assign res_byte_idx    = res_byte_idx_q;
    assign res_single_byte = res_single_q;
    assign res_last        = res_last_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_dfa_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_dfa_sequencer
//  Description : Bench with a behavioural faultable AES-128 core and scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_dfa_sequencer;

    localparam int LAT      = 11;
    localparam int FAULT_AT = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready;
    logic [127:0] cmd_pt, cmd_key;
    logic [6:0]   cmd_bit_start, cmd_count;
    logic [127:0] aes_state, aes_key, aes_out;
    logic         aes_fault_en;
    logic [6:0]   aes_fault_bit;
    logic         res_valid, res_ready;
    logic [127:0] res_golden, res_faulty, res_diff;
    logic [6:0]   res_fault_bit;
    logic [3:0]   res_byte_idx;
    logic         res_single_byte, res_last, busy;

    aes_dfa_sequencer #(.LAT(LAT), .FAULT_AT(FAULT_AT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pt(cmd_pt), .cmd_key(cmd_key),
        .cmd_bit_start(cmd_bit_start), .cmd_count(cmd_count),
        .aes_state(aes_state), .aes_key(aes_key), .aes_fault_en(aes_fault_en),
        .aes_fault_bit(aes_fault_bit), .aes_out(aes_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_golden(res_golden),
        .res_faulty(res_faulty), .res_diff(res_diff), .res_fault_bit(res_fault_bit),
        .res_byte_idx(res_byte_idx), .res_single_byte(res_single_byte),
        .res_last(res_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] r, base;
        int e;
        r = 8'h01; base = x; e = 254;
        while (e > 0) begin
            if (e % 2 == 1) r = gmul(r, base);
            base = gmul(base, base);
            e = e / 2;
        end
        if (x == 8'h00) r = 8'h00;
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    initial for (int i = 0; i < 256; i++) sbox[i] = sbox_calc(8'(i));

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = sbox[s[127-8*(4*((c+r)%4)+r) -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key,
                                             input logic flt, input logic [6:0] fb);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rcon;
        logic [127:0] s;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 9; r++) s = mix(sub_shift(s)) ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        if (flt) s[fb] = ~s[fb];
        return sub_shift(s) ^ {w[40], w[41], w[42], w[43]};
    endfunction

    // Behavioural core: ciphertext of the launch-cycle inputs appears LAT cycles later,
    // with the round-9 output faulted if fault_en was high at launch + LAT - 1.
    logic [255:0] pipe [0:LAT-2];
    always @(posedge clk) begin
        pipe[0] <= {aes_state, aes_key};
        for (int i = 1; i <= LAT - 2; i++) pipe[i] <= pipe[i-1];
        aes_out <= aes_enc(pipe[LAT-2][255:128], pipe[LAT-2][127:0], aes_fault_en, aes_fault_bit);
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [127:0] golden, faulty, diff;
        logic [6:0]   fbit;
        logic [3:0]   idx;
        logic         single, last;
    } exp_t;
    exp_t sb[$];

    function automatic void analyse(input logic [127:0] d, output logic [3:0] idx, output logic single);
        int nz = 0;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (((d >> (8*(15-i))) & 128'hff) != 128'h0) begin nz++; idx = 4'(i); end
        single = (nz == 1);
    endfunction

    int           res_count;
    logic [127:0] last_golden, last_diff;
    logic [6:0]   last_bit;
    logic [3:0]   last_idx;
    logic         last_single, last_last;

    logic         held, in_cmd, exp_last_flag;
    int           exp_fe_cyc, exp_valid_cyc;
    logic [396:0] snap, cur;
    exp_t         me;

    initial begin
        held = 0; in_cmd = 0; exp_fe_cyc = -1; exp_valid_cyc = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete(); held = 0; in_cmd = 0; exp_fe_cyc = -1; exp_valid_cyc = -1;
            end else begin
                chk("cmd_ready", cmd_ready, !in_cmd);
                chk("busy", busy, in_cmd);
                chk("fault_en_timing", aes_fault_en, cyc == exp_fe_cyc);
                if (cyc == exp_fe_cyc && sb.size() > 0) chk("fault_bit", aes_fault_bit, sb[0].fbit);
                if (cmd_valid && cmd_ready) begin
                    in_cmd        = 1;
                    exp_fe_cyc    = cyc + 1 + (LAT + 1) + FAULT_AT;
                    exp_valid_cyc = cyc + 1 + 2 * (LAT + 1);
                end
                if (res_valid) begin
                    cur = {res_golden, res_faulty, res_diff, res_fault_bit, res_byte_idx,
                           res_single_byte, res_last};
                    if (!held) begin
                        chk("res_latency", cyc, exp_valid_cyc);
                        if (sb.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL unexpected_result: got bit %0d expected no result", res_fault_bit);
                        end else begin
                            chk("res_golden", res_golden, sb[0].golden);
                            chk("res_faulty", res_faulty, sb[0].faulty);
                            chk("res_diff", res_diff, sb[0].diff);
                            chk("res_fault_bit", res_fault_bit, sb[0].fbit);
                            chk("res_byte_idx", res_byte_idx, sb[0].idx);
                            chk("res_single_byte", res_single_byte, sb[0].single);
                            chk("res_last", res_last, sb[0].last);
                        end
                        snap = cur;
                    end else begin
                        n_checks++;
                        if (cur !== snap) begin
                            n_fail++;
                            $display("FAIL res_stable: got %h expected %h", cur, snap);
                        end
                    end
                    if (res_ready) begin
                        res_count++;
                        last_golden = res_golden; last_diff = res_diff; last_bit = res_fault_bit;
                        last_idx = res_byte_idx; last_single = res_single_byte; last_last = res_last;
                        exp_last_flag = res_last;
                        if (sb.size() > 0) begin
                            me = sb.pop_front();
                            exp_last_flag = me.last;
                        end
                        held = 0;
                        if (exp_last_flag) in_cmd = 0;
                        else begin
                            exp_fe_cyc    = cyc + 1 + FAULT_AT;
                            exp_valid_cyc = cyc + 1 + LAT + 1;
                        end
                    end else held = 1;
                end
            end
        end
    end

    // ---------------- result-ready driver ----------------
    int ready_mode = 0;
    int hold_cnt   = 0;
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: res_ready = 1'b1;
                1: res_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (res_valid && hold_cnt < 20) begin res_ready = 1'b0; hold_cnt++; end
                    else res_ready = 1'b1;
                end
            endcase
        end
    end

    // ---------------- command driver ----------------
    task automatic issue_cmd(input logic [127:0] pt, input logic [127:0] key,
                             input logic [6:0] start, input logic [6:0] cnt);
        int   n;
        exp_t e;
        logic [127:0] g;
        n = (cnt == 7'd0) ? 128 : int'(cnt);
        g = aes_enc(pt, key, 1'b0, 7'd0);
        for (int j = 0; j < n; j++) begin
            e.golden = g;
            e.fbit   = start + 7'(j);
            e.faulty = aes_enc(pt, key, 1'b1, e.fbit);
            e.diff   = e.golden ^ e.faulty;
            analyse(e.diff, e.idx, e.single);
            e.last   = (j == n - 1);
            sb.push_back(e);
        end
        res_count = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_pt = pt; cmd_key = key; cmd_bit_start = start; cmd_count = cnt;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        @(posedge clk); #1;
        // Keep offering junk commands while busy; they must be ignored.
        repeat (4) begin
            cmd_pt = {$urandom, $urandom, $urandom, $urandom};
            cmd_key = {$urandom, $urandom, $urandom, $urandom};
            cmd_bit_start = 7'($urandom); cmd_count = 7'($urandom);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int g;
        for (g = 0; g < limit; g++) begin
            @(negedge clk); #2;
            if (sb.size() == 0) break;
        end
        if (g >= limit) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: got %0d pending expected 0", sb.size());
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
        end else begin
            @(negedge clk); #2;
            chk("cmd_ready_after_last", cmd_ready, 1'b1);
        end
    endtask

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;

    initial begin
        logic [6:0] st;
        int         fe_wait;
        rst = 1'b1; cmd_valid = 1'b0; cmd_pt = '0; cmd_key = '0;
        cmd_bit_start = '0; cmd_count = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_fault_en", aes_fault_en, 1'b0);
        chk("rst_aes_state", aes_state, 128'h0);
        chk("rst_res_golden", res_golden, 128'h0);
        @(posedge clk); #1 rst = 1'b0;

        issue_cmd(FIPS_PT, FIPS_KEY, 7'd0, 7'd1);
        wait_done(200);
        chk("fips_golden", last_golden, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("bit0_fault_bit", last_bit, 7'd0);
        chk("bit0_byte_idx", last_idx, 4'd3);
        chk("bit0_single", last_single, 1'b1);
        chk("bit0_last", last_last, 1'b1);
        chk("bit0_count", res_count, 1);

        issue_cmd(FIPS_PT, FIPS_KEY, 7'd127, 7'd1);
        wait_done(200);
        chk("bit127_byte_idx", last_idx, 4'd0);
        chk("bit127_single", last_single, 1'b1);
        chk("bit127_diff_rest", last_diff[119:0], 120'h0);

        ready_mode = 1;
        issue_cmd(FIPS_PT, FIPS_KEY, 7'd126, 7'd4);
        wait_done(500);
        chk("wrap_count", res_count, 4);
        chk("wrap_last_bit", last_bit, 7'd1);

        ready_mode = 0;
        st = 7'($urandom);
        issue_cmd({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                  st, 7'd0);
        wait_done(3000);
        chk("sweep_count", res_count, 128);
        chk("sweep_last_bit", last_bit, st - 7'd1);

        ready_mode = 2; hold_cnt = 0;
        issue_cmd({$urandom, $urandom, $urandom, $urandom}, FIPS_KEY, 7'($urandom), 7'd2);
        wait_done(300);
        chk("bp_count", res_count, 2);

        ready_mode = 1;
        for (int t = 0; t < 5; t++) begin
            issue_cmd({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                      7'($urandom), 7'($urandom_range(1, 5)));
            wait_done(600);
        end

        ready_mode = 0;
        issue_cmd(FIPS_PT, FIPS_KEY, 7'd10, 7'd3);
        for (fe_wait = 0; fe_wait < 100; fe_wait++) begin
            @(negedge clk); #2;
            if (aes_fault_en) break;
        end
        chk("midrun_fault_seen", fe_wait < 100, 1'b1);
        rst = 1'b1;
        @(negedge clk); #2;
        chk("midrun_fault_en", aes_fault_en, 1'b0);
        chk("midrun_res_valid", res_valid, 1'b0);
        chk("midrun_busy", busy, 1'b0);
        chk("midrun_cmd_ready", cmd_ready, 1'b1);
        rst = 1'b0;
        issue_cmd(FIPS_PT, FIPS_KEY, 7'd5, 7'd2);
        wait_done(300);
        chk("post_rst_count", res_count, 2);
        chk("post_rst_golden", last_golden, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
